// File: rtl/i2s_lj16_frame_ctrl_pkg.sv
// Shared types and constants for the I2S to 16-bit LJ frame controller.
// FSM states, slot counter width and framing constants.
package i2s_pkg;
  localparam int OUT_BITS = 16;
  localparam int MIN_LEN  = 16;
  localparam int SLOT_W   = 6;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [SLOT_W:0]   len_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_LOCKED
  } state_e;

  function automatic logic in_window(slot_t s);
    return (s >= slot_t'(1)) && (s <= slot_t'(OUT_BITS));
  endfunction
endpackage

// File: rtl/i2s_lj16_frame_ctrl_if.sv
// Pin bundle between I2S receive pins, frame controller and the
// downstream 16-bit LJ serializer.
interface i2s_lj16_frame_ctrl_if;
  logic           lrck;
  logic           sdata_in;
  logic           lrck_out;
  logic           sdata_out;
  logic           data_en;
  logic           word_start;
  logic           locked;
  i2s_pkg::slot_t half_len;
  logic           err;

  modport master (
    output lrck, sdata_in,
    input  lrck_out, sdata_out, data_en,
    input  word_start, locked, half_len, err
  );

  modport slave (
    input  lrck, sdata_in,
    output lrck_out, sdata_out, data_en,
    output word_start, locked, half_len, err
  );
endinterface

// File: rtl/i2s_lj16_frame_ctrl_lrck_slot_counter.sv
// LRCK sampler: edge pulse, saturating slot index and the length
// of the half-frame that just ended.
module lrck_slot_counter
  import i2s_pkg::*;
#(
  parameter int MAX_BITS = 32
) (
  input  logic  bck,
  input  logic  rst_n,
  input  logic  lrck_i,
  output logic  edge_o,
  output slot_t slot_o,
  output len_t  len_o,
  output logic  ovf_o
);
  localparam slot_t SAT = slot_t'(MAX_BITS + 1);

  logic  lrck_q, lrck_d;
  logic  vld_q, vld_d;
  slot_t s_q, s_d;
  logic  edge_w;

  // first sample after reset only primes lrck_q
  assign edge_w = vld_q && (lrck_i != lrck_q);

  always_comb begin
    lrck_d = lrck_i;
    vld_d  = 1'b1;
    s_d    = s_q;
    if (edge_w)
      s_d = '0;
    else if (s_q != SAT)
      s_d = s_q + 1'b1;
  end

  always_ff @(posedge bck) begin
    if (!rst_n) begin
      lrck_q <= 1'b0;
      vld_q  <= 1'b0;
      s_q    <= '0;
    end else begin
      lrck_q <= lrck_d;
      vld_q  <= vld_d;
      s_q    <= s_d;
    end
  end

  assign edge_o = edge_w;
  assign slot_o = s_d;
  assign len_o  = len_t'(s_q) + len_t'(1);
  assign ovf_o  = (s_d == SAT);
endmodule

// File: rtl/i2s_lj16_frame_ctrl.sv
// Frame-lock FSM and LJ output framing for the I2S to 16-bit LJ path.
// Everything runs on posedge bck with one register of output latency.
module i2s_lj16_frame_ctrl
  import i2s_pkg::*;
#(
  parameter int MAX_BITS    = 32,
  parameter int LOCK_FRAMES = 2
) (
  input logic                  bck,
  input logic                  rst_n,
  i2s_lj16_frame_ctrl_if.slave io
);
  localparam len_t       MAX_L  = len_t'(MAX_BITS);
  localparam len_t       MIN_L  = len_t'(MIN_LEN);
  localparam len_t       OUT_L  = len_t'(OUT_BITS);
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  logic  edge_w, ovf_w, legal_w, lose_w;
  slot_t slot_w;
  len_t  len_w;

  state_e     state_q, state_d;
  slot_t      stored_q, stored_d;
  logic [3:0] match_q, match_d, match_inc;
  slot_t      hlen_q, hlen_d;
  logic       lock_q, lock_d;
  logic       err_q, err_d;
  logic       de_q, de_d;
  logic       ws_q, ws_d;
  logic       sd_q, sd_d;
  logic       lro_q, lro_d;

  lrck_slot_counter #(
    .MAX_BITS (MAX_BITS)
  ) u_cnt (
    .bck    (bck),
    .rst_n  (rst_n),
    .lrck_i (io.lrck),
    .edge_o (edge_w),
    .slot_o (slot_w),
    .len_o  (len_w),
    .ovf_o  (ovf_w)
  );

  assign legal_w = (len_w >= MIN_L) && (len_w <= MAX_L);

  always_comb begin
    state_d   = state_q;
    stored_d  = stored_q;
    match_d   = match_q;
    match_inc = 4'd1;
    hlen_d    = hlen_q;
    lock_d    = lock_q;
    err_d     = 1'b0;
    lose_w    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        stored_d = '0;
        match_d  = '0;
        if (edge_w)
          state_d = ST_MEASURE;
      end
      ST_MEASURE: begin
        if (edge_w && legal_w) begin
          if (len_w == len_t'(stored_q))
            match_inc = match_q + 4'd1;
          else
            stored_d = len_w[SLOT_W-1:0];
          match_d = match_inc;
          if (match_inc >= LOCK_N) begin
            state_d = ST_LOCKED;
            lock_d  = 1'b1;
            hlen_d  = len_w[SLOT_W-1:0];
          end
        end else if (edge_w || ovf_w) begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        // an edge inside the 16-bit window is also a framing fault
        if (edge_w)
          lose_w = !legal_w || (len_w != len_t'(hlen_q)) ||
                   (len_w <= OUT_L);
        else
          lose_w = ovf_w;
        if (lose_w) begin
          state_d = ST_IDLE;
          lock_d  = 1'b0;
          hlen_d  = '0;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    de_d  = (state_q == ST_LOCKED) && in_window(slot_w) && !lose_w;
    ws_d  = de_d && (slot_w == slot_t'(1));
    sd_d  = de_d && io.sdata_in;
    lro_d = (slot_w == slot_t'(1)) ? io.lrck : lro_q;
  end

  always_ff @(posedge bck) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      stored_q <= '0;
      match_q  <= '0;
      hlen_q   <= '0;
      lock_q   <= 1'b0;
      err_q    <= 1'b0;
      de_q     <= 1'b0;
      ws_q     <= 1'b0;
      sd_q     <= 1'b0;
      lro_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      stored_q <= stored_d;
      match_q  <= match_d;
      hlen_q   <= hlen_d;
      lock_q   <= lock_d;
      err_q    <= err_d;
      de_q     <= de_d;
      ws_q     <= ws_d;
      sd_q     <= sd_d;
      lro_q    <= lro_d;
    end
  end

  assign io.lrck_out   = lro_q;
  assign io.sdata_out  = sd_q;
  assign io.data_en    = de_q;
  assign io.word_start = ws_q;
  assign io.locked     = lock_q;
  assign io.half_len   = hlen_q;
  assign io.err        = err_q;
endmodule

// File: tb/tb_i2s_lj16_frame_ctrl.sv
// Directed bench for i2s_lj16_frame_ctrl: lock, framing, data,
// length change, overflow, short frames and mid-word reset.
module tb_i2s_lj16_frame_ctrl;
  logic bck = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [63:0] de_v, ws_v, sd_v, err_v, lk_v, lro_v;
  logic [5:0]  hl0;
  logic [11:0] outs;

  i2s_lj16_frame_ctrl_if io();

  i2s_lj16_frame_ctrl #(
    .MAX_BITS    (32),
    .LOCK_FRAMES (2)
  ) dut (
    .bck   (bck),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 bck = ~bck;

  task automatic step(input logic l, input logic d);
    io.lrck     = l;
    io.sdata_in = d;
    @(posedge bck);
    #1;
  endtask

  task automatic grab(input int i);
    de_v[i]  = io.data_en;
    ws_v[i]  = io.word_start;
    sd_v[i]  = io.sdata_out;
    err_v[i] = io.err;
    lk_v[i]  = io.locked;
    lro_v[i] = io.lrck_out;
    if (i == 0)
      hl0 = io.half_len;
  endtask

  task automatic half(input logic l, input int len,
                      input logic [15:0] w, input logic trail);
    logic b;
    de_v  = '0;
    ws_v  = '0;
    sd_v  = '0;
    err_v = '0;
    lk_v  = '0;
    lro_v = '0;
    for (int i = 0; i < len; i++) begin
      if (i >= 1 && i <= 16)
        b = w[16-i];
      else if (i > 16)
        b = trail;
      else
        b = 1'b0;
      step(l, b);
      grab(i);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic acquire();
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0);
    half(1'b0, 32, 16'h0, 1'b0);
    half(1'b1, 32, 16'h0, 1'b0);
    n_cmp++;
    if (lk_v !== 64'h0) begin
      n_bad++;
      $display("FAIL acq_early_lock got %h want %h", lk_v, 64'h0);
    end
    half(1'b0, 32, 16'h0, 1'b0);
    n_cmp++;
    if (lk_v !== 64'hFFFF_FFFF) begin
      n_bad++;
      $display("FAIL acq_lock got %h want %h", lk_v, 64'hFFFF_FFFF);
    end
    n_cmp++;
    if (hl0 !== 6'd32) begin
      n_bad++;
      $display("FAIL acq_half_len got %0d want 32", hl0);
    end
  endtask

  task automatic test_reset();
    do_reset();
    outs = {io.lrck_out, io.sdata_out, io.data_en, io.word_start,
            io.locked, io.err, io.half_len};
    n_cmp++;
    if (outs !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outs got %h want %h", outs, 12'h000);
    end
  endtask

  task automatic test_lock32();
    acquire();
    n_cmp++;
    if (de_v !== 64'h1FFFE) begin
      n_bad++;
      $display("FAIL lock_data_en got %h want %h", de_v, 64'h1FFFE);
    end
    n_cmp++;
    if (ws_v !== 64'h2) begin
      n_bad++;
      $display("FAIL lock_word_start got %h want %h", ws_v, 64'h2);
    end
    n_cmp++;
    if (lro_v !== 64'h1) begin
      n_bad++;
      $display("FAIL lock_lrck_out got %h want %h", lro_v, 64'h1);
    end
  endtask

  task automatic test_word();
    half(1'b1, 32, 16'h0, 1'b0);
    n_cmp++;
    if (lro_v !== 64'hFFFF_FFFE) begin
      n_bad++;
      $display("FAIL word_lrck_r got %h want %h", lro_v, 64'hFFFF_FFFE);
    end
    half(1'b0, 32, 16'hA5C3, 1'b0);
    n_cmp++;
    if (sd_v !== 64'h1874A) begin
      n_bad++;
      $display("FAIL word_sdata got %h want %h", sd_v, 64'h1874A);
    end
    n_cmp++;
    if (lro_v !== 64'h1) begin
      n_bad++;
      $display("FAIL word_lrck_l got %h want %h", lro_v, 64'h1);
    end
  endtask

  task automatic test_len_change();
    half(1'b1, 32, 16'h0, 1'b0);
    half(1'b0, 24, 16'h0, 1'b0);
    n_cmp++;
    if (de_v !== 64'h1FFFE) begin
      n_bad++;
      $display("FAIL len_de_before got %h want %h", de_v, 64'h1FFFE);
    end
    half(1'b1, 24, 16'h0, 1'b0);
    n_cmp++;
    if (err_v !== 64'h1) begin
      n_bad++;
      $display("FAIL len_err got %h want %h", err_v, 64'h1);
    end
    n_cmp++;
    if (lk_v !== 64'h0 || de_v !== 64'h0) begin
      n_bad++;
      $display("FAIL len_drop got lk=%h de=%h want 0", lk_v, de_v);
    end
    n_cmp++;
    if (hl0 !== 6'd0) begin
      n_bad++;
      $display("FAIL len_hl_clear got %0d want 0", hl0);
    end
    half(1'b0, 24, 16'h0, 1'b0);
    half(1'b1, 24, 16'h0, 1'b0);
    n_cmp++;
    if (lk_v !== 64'h0) begin
      n_bad++;
      $display("FAIL len_early got %h want %h", lk_v, 64'h0);
    end
    half(1'b0, 24, 16'h0, 1'b0);
    n_cmp++;
    if (lk_v !== 64'hFF_FFFF) begin
      n_bad++;
      $display("FAIL len_relock got %h want %h", lk_v, 64'hFF_FFFF);
    end
    n_cmp++;
    if (hl0 !== 6'd24) begin
      n_bad++;
      $display("FAIL len_hl24 got %0d want 24", hl0);
    end
  endtask

  task automatic test_overflow();
    half(1'b1, 40, 16'h0, 1'b1);
    n_cmp++;
    if (err_v !== 64'h2_0000_0000) begin
      n_bad++;
      $display("FAIL ovf_err got %h want %h", err_v, 64'h2_0000_0000);
    end
    n_cmp++;
    if (lk_v !== 64'h1_FFFF_FFFF) begin
      n_bad++;
      $display("FAIL ovf_lock got %h want %h", lk_v, 64'h1_FFFF_FFFF);
    end
    n_cmp++;
    if (de_v !== 64'h1FFFE) begin
      n_bad++;
      $display("FAIL ovf_de got %h want %h", de_v, 64'h1FFFE);
    end
    n_cmp++;
    if (sd_v !== 64'h0) begin
      n_bad++;
      $display("FAIL ovf_sdata got %h want %h", sd_v, 64'h0);
    end
  endtask

  task automatic test_short();
    logic [63:0] lk_acc, de_acc;
    lk_acc = '0;
    de_acc = '0;
    for (int k = 0; k < 8; k++) begin
      half(k[0], 12, 16'hFFFF, 1'b1);
      lk_acc |= lk_v;
      de_acc |= de_v;
    end
    n_cmp++;
    if (lk_acc !== 64'h0) begin
      n_bad++;
      $display("FAIL short_lock got %h want %h", lk_acc, 64'h0);
    end
    n_cmp++;
    if (de_acc !== 64'h0) begin
      n_bad++;
      $display("FAIL short_de got %h want %h", de_acc, 64'h0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    acquire();
    half(1'b1, 32, 16'h0, 1'b0);
    de_v = '0;
    for (int i = 0; i < 32; i++) begin
      rst_n = (i != 8);
      step(1'b0, 1'b1);
      de_v[i] = io.data_en;
      if (i == 8) begin
        outs = {io.lrck_out, io.sdata_out, io.data_en, io.word_start,
                io.locked, io.err, io.half_len};
        n_cmp++;
        if (outs !== 12'h000) begin
          n_bad++;
          $display("FAIL rmid_outs got %h want %h", outs, 12'h000);
        end
      end
    end
    rst_n = 1'b1;
    n_cmp++;
    if (de_v !== 64'hFE) begin
      n_bad++;
      $display("FAIL rmid_de got %h want %h", de_v, 64'hFE);
    end
    half(1'b1, 32, 16'h0, 1'b0);
    half(1'b0, 32, 16'h0, 1'b0);
    n_cmp++;
    if (lk_v !== 64'h0) begin
      n_bad++;
      $display("FAIL rmid_early got %h want %h", lk_v, 64'h0);
    end
    half(1'b1, 32, 16'h0, 1'b0);
    n_cmp++;
    if (lk_v !== 64'hFFFF_FFFF || hl0 !== 6'd32) begin
      n_bad++;
      $display("FAIL rmid_relock got lk=%h hl=%0d want ffffffff/32",
               lk_v, hl0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    io.lrck     = 1'b0;
    io.sdata_in = 1'b0;
    test_reset();
    test_lock32();
    test_word();
    test_len_change();
    test_overflow();
    test_short();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
